gps_round_sched: RTL

//  Sequencer for the gps code-generator datapath. Walks a slot table of SV numbers,

---
 rtl/gps_round_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/gps_round_sched.sv
// Round sequencer for the gps code generator: walks an SV slot table, one round in flight, results on valid/ready.
// Optional WAIT watchdog enabled by defining GPS_SCHED_TIMEOUT_EN.
module gps_round_sched #(
  parameter int NUM_SLOTS   = 8,
  parameter int START_HOLD  = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          sys_clk_50,
  input  logic                          sync_rst_in,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0]  cfg_slot,
  input  logic [5:0]                    cfg_sv,
  input  logic [NUM_SLOTS-1:0]          cfg_mask,
  input  logic                          run,
  output logic [5:0]                    sv_num,
  output logic                          startRound,
  input  logic [12:0]                   ca_code_in,
  input  logic [127:0]                  p_code_in,
  input  logic [127:0]                  l_code_in,
  input  logic                          l_code_valid,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_SLOTS)-1:0]  res_slot,
  output logic [5:0]                    res_sv,
  output logic [12:0]                   res_ca,
  output logic [127:0]                  res_p,
  output logic [127:0]                  res_l,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic                          timeout_err
);

  localparam int SW   = $clog2(NUM_SLOTS);
  localparam int HMAX = (START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES;
  localparam int CW   = $clog2(HMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT, S_CAPTURE, S_GAP
  } state_t;

  state_t               state_q;
  logic [5:0]           table_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] mask_q;
  logic [SW:0]          ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [5:0]           sv_num_q;
  logic                 start_q;
  logic                 res_valid_q;
  logic [SW-1:0]        res_slot_q;
  logic [5:0]           res_sv_q;
  logic [12:0]          res_ca_q;
  logic [127:0]         res_p_q;
  logic [127:0]         res_l_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic                 sel_found_d;
  logic [SW-1:0]        sel_idx_d;

`ifdef GPS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]        wcnt_q;
  logic                 timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  localparam int timeout_cyc_unused = TIMEOUT_CYC;
  assign timeout_err = 1'b0;
`endif

  // Lowest enabled slot at or above the pointer; a wrapped pointer (MSB set) finds nothing.
  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask_q[i] && ((SW+1)'(i) >= ptr_q)) begin
        sel_found_d = 1'b1;
        sel_idx_d   = SW'(i);
      end
    end
  end

  always_ff @(posedge sys_clk_50) begin
    if (sync_rst_in) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) table_q[i] <= '0;
      mask_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sv_num_q    <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_slot_q  <= '0;
      res_sv_q    <= '0;
      res_ca_q    <= '0;
      res_p_q     <= '0;
      res_l_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef GPS_SCHED_TIMEOUT_EN
      wcnt_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      if (cfg_we) begin
        if (state_q == S_IDLE) table_q[cfg_slot] <= cfg_sv;
        else                   cfg_err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (run) begin
            mask_q  <= cfg_mask;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SELECT;
`ifdef GPS_SCHED_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
          end
        end
        S_SELECT: begin
          if (sel_found_d) begin
            sv_num_q <= table_q[sel_idx_d];
            ptr_q    <= {1'b0, sel_idx_d};
            start_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= S_START;
          end else begin
            // busy stays high through the done cycle and drops on the next IDLE cycle
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          if (cnt_q == CW'(START_HOLD - 1)) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WAIT;
`ifdef GPS_SCHED_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (l_code_valid) begin
            res_ca_q    <= ca_code_in;
            res_p_q     <= p_code_in;
            res_l_q     <= l_code_in;
            res_slot_q  <= ptr_q[SW-1:0];
            res_sv_q    <= sv_num_q;
            res_valid_q <= 1'b1;
            state_q     <= S_CAPTURE;
          end
`ifdef GPS_SCHED_TIMEOUT_EN
          else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_err_q <= 1'b1;
            ptr_q         <= ptr_q + (SW+1)'(1);
            cnt_q         <= '0;
            state_q       <= S_GAP;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
          end
`endif
        end
        S_CAPTURE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            ptr_q       <= ptr_q + (SW+1)'(1);
            cnt_q       <= '0;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_SELECT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sv_num     = sv_num_q;
  assign startRound = start_q;
  assign res_valid  = res_valid_q;
  assign res_slot   = res_slot_q;
  assign res_sv     = res_sv_q;
  assign res_ca     = res_ca_q;
  assign res_p      = res_p_q;
  assign res_l      = res_l_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule
